// File: rtl/ulaplus_pkg.sv
// ulaplus_pkg: shared ULAplus group codes, port numbers and write-FSM states
package ulaplus_pkg;
    localparam logic [1:0]  UP_GRP_PAL    = 2'b00;
    localparam logic [1:0]  UP_GRP_MODE   = 2'b01;
    localparam logic [15:0] UP_PORT_SEL   = 16'hBF3B;
    localparam logic [15:0] UP_PORT_DATA  = 16'hFF3B;
    localparam int          SHADOW_RD_LAT = 2;
    typedef enum logic {IDLE, PEND} wr_state_e;
endpackage

// File: rtl/ulaplus_shadow_ram.sv
// ulaplus_shadow_ram: 64x8 simple dual-port RAM with registered read (read-old on collision)
module ulaplus_shadow_ram (
    input  logic       clk,
    input  logic       we,
    input  logic [5:0] waddr,
    input  logic [7:0] wdata,
    input  logic [5:0] raddr,
    output logic [7:0] rdata
);
    logic [7:0] mem [64];
    // single write port, registered read port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/ulaplus_ports.sv
// ulaplus_ports: ULAplus #BF3B/#FF3B register pair driving the mixer palette port
module ulaplus_ports
    import ulaplus_pkg::*;
#(
    parameter logic RST_ENA = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_wr,
    input  logic       data_wr,
    input  logic       rd_stb,
    input  logic [7:0] din,
    input  logic       atm_palwr,
    output logic [7:0] dout,
    output logic       dout_rdy,
    output logic       up_ena,
    output logic       up_palwr,
    output logic [5:0] up_paladdr,
    output logic [7:0] up_paldata,
    output logic       busy
);
    logic [1:0] group, rd_grp;
    logic [5:0] index;
    logic       mode, rd_mode, rd_p1, pal_wr, rd_done;
    logic [7:0] ram_q;
    wr_state_e  state, state_nx;

    assign pal_wr  = data_wr && (group == UP_GRP_PAL);
    assign rd_done = rd_p1 && !rd_stb;
    assign up_ena  = mode;

    ulaplus_shadow_ram u_shadow (
        .clk  (clk),
        .we   (pal_wr),
        .waddr(index),
        .wdata(din),
        .raddr(index),
        .rdata(ram_q)
    );

    // register select and mode; data_wr sees the selection from before any same-cycle sel_wr
    always_ff @(posedge clk) begin
        if (rst) begin
            group <= '0;
            index <= '0;
            mode  <= RST_ENA;
        end else begin
            if (sel_wr) begin
                group <= din[7:6];
                index <= din[5:0];
            end
            if (data_wr && group == UP_GRP_MODE) mode <= din[0];
        end
    end

    // latest palette write wins the pending request
    always_ff @(posedge clk) begin
        if (rst) begin
            up_paladdr <= '0;
            up_paldata <= '0;
        end else if (pal_wr) begin
            up_paladdr <= index;
            up_paldata <= din;
        end
    end

    // write FSM state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end

    // pend until a cycle without ATM ownership commits the entry
    always_comb begin
        state_nx = state;
        up_palwr = state == PEND;
        busy     = state == PEND;
        if (pal_wr) state_nx = PEND;
        else if (state == PEND && !atm_palwr) state_nx = IDLE;
    end

    // two-stage readback; a new rd_stb restarts the pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_p1    <= 1'b0;
            rd_grp   <= '0;
            rd_mode  <= 1'b0;
            dout_rdy <= 1'b0;
            dout     <= '0;
        end else begin
            rd_p1    <= rd_stb;
            dout_rdy <= rd_done;
            if (rd_stb) begin
                rd_grp  <= group;
                rd_mode <= mode;
            end
            if (rd_done)
                dout <= rd_grp == UP_GRP_PAL  ? ram_q :
                        rd_grp == UP_GRP_MODE ? {7'b0, rd_mode} : 8'hFF;
        end
    end
endmodule

// File: tb/tb_ulaplus_ports.sv
// tb_ulaplus_ports: directed self-checking bench for ulaplus_ports
module tb_ulaplus_ports;
    import ulaplus_pkg::*;
    logic       clk = 0, rst = 0, sel_wr = 0, data_wr = 0, rd_stb = 0, atm_palwr = 0;
    logic [7:0] din = 0;
    logic [7:0] dout, up_paldata;
    logic       dout_rdy, up_ena, up_palwr, busy;
    logic [5:0] up_paladdr;
    int checks = 0, errors = 0;

    ulaplus_ports #(.RST_ENA(1'b0)) dut (
        .clk(clk), .rst(rst), .sel_wr(sel_wr), .data_wr(data_wr), .rd_stb(rd_stb),
        .din(din), .atm_palwr(atm_palwr), .dout(dout), .dout_rdy(dout_rdy),
        .up_ena(up_ena), .up_palwr(up_palwr), .up_paladdr(up_paladdr),
        .up_paldata(up_paldata), .busy(busy)
    );

    always #18 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sel(input logic [7:0] d);
        sel_wr = 1; din = d;
        tick();
        sel_wr = 0;
    endtask

    task automatic wr(input logic [7:0] d);
        data_wr = 1; din = d;
        tick();
        data_wr = 0;
    endtask

    task automatic rd(output logic [7:0] v, output logic r);
        rd_stb = 1;
        tick();
        rd_stb = 0;
        repeat (SHADOW_RD_LAT - 1) tick();
        v = dout; r = dout_rdy;
    endtask

    task automatic test_reset();
        rst = 1; tick(); rst = 0;
        checks++;
        if ({up_palwr, busy, up_ena, dout_rdy} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {up_palwr, busy, up_ena, dout_rdy});
        end
        checks++;
        if ({dout, up_paladdr, up_paldata} !== 22'h0) begin
            errors++; $display("FAIL reset_data got %h/%h/%h exp 0", dout, up_paladdr, up_paldata);
        end
    endtask

    task automatic test_palette_write();
        sel(8'h05); wr(8'hE3);
        checks++;
        if ({up_palwr, busy, up_paladdr, up_paldata} !== {2'b11, 6'h05, 8'hE3}) begin
            errors++; $display("FAIL pal_req got %b%b %h %h exp 11 05 e3", up_palwr, busy, up_paladdr, up_paldata);
        end
        tick();
        checks++;
        if ({up_palwr, busy} !== 2'b00) begin
            errors++; $display("FAIL pal_commit got %b%b exp 00", up_palwr, busy);
        end
    endtask

    task automatic test_mode();
        logic [7:0] v; logic r;
        sel(8'h40); wr(8'h01);
        checks++;
        if ({up_ena, up_palwr} !== 2'b10) begin
            errors++; $display("FAIL mode_wr got ena=%b palwr=%b exp 1 0", up_ena, up_palwr);
        end
        rd(v, r);
        checks++;
        if ({r, v} !== {1'b1, 8'h01} || up_palwr !== 1'b0) begin
            errors++; $display("FAIL mode_rd got rdy=%b dout=%h palwr=%b exp 1 01 0", r, v, up_palwr);
        end
    endtask

    task automatic test_atm();
        logic [7:0] v; logic r;
        sel(8'h3F);
        atm_palwr = 1;
        repeat (5) tick();
        wr(8'h1C);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({up_palwr, busy, up_paladdr, up_paldata} !== {2'b11, 6'h3F, 8'h1C}) begin
                errors++; $display("FAIL atm_hold[%0d] got %b%b %h %h exp 11 3f 1c", i, up_palwr, busy, up_paladdr, up_paldata);
            end
            tick();
        end
        atm_palwr = 0;
        #1;
        checks++;
        if (up_palwr !== 1'b1) begin
            errors++; $display("FAIL atm_commit_cycle got %b exp 1", up_palwr);
        end
        tick();
        checks++;
        if ({up_palwr, busy} !== 2'b00) begin
            errors++; $display("FAIL atm_release got %b%b exp 00", up_palwr, busy);
        end
        rd(v, r);
        checks++;
        if ({r, v} !== {1'b1, 8'h1C}) begin
            errors++; $display("FAIL atm_rd got %b %h exp 1 1c", r, v);
        end
    endtask

    task automatic test_overwrite();
        logic [7:0] v; logic r;
        atm_palwr = 1;
        sel(8'h01); wr(8'hAA); sel(8'h02); wr(8'h55);
        checks++;
        if ({up_palwr, up_paladdr, up_paldata} !== {1'b1, 6'h02, 8'h55}) begin
            errors++; $display("FAIL ovw_req got %b %h %h exp 1 02 55", up_palwr, up_paladdr, up_paldata);
        end
        atm_palwr = 0;
        tick();
        checks++;
        if (up_palwr !== 1'b0) begin
            errors++; $display("FAIL ovw_commit got %b exp 0", up_palwr);
        end
        sel(8'h01); rd(v, r);
        checks++;
        if ({r, v} !== {1'b1, 8'hAA}) begin
            errors++; $display("FAIL ovw_rd1 got %b %h exp 1 aa", r, v);
        end
        sel(8'h02); rd(v, r);
        checks++;
        if ({r, v} !== {1'b1, 8'h55}) begin
            errors++; $display("FAIL ovw_rd2 got %b %h exp 1 55", r, v);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] v; logic r;
        for (int i = 0; i < 64; i++) begin
            sel(8'(i)); wr(8'(i) ^ 8'hA5);
        end
        tick();
        for (int i = 0; i < 64; i++) begin
            sel(8'(i)); rd(v, r);
            checks++;
            if ({r, v} !== {1'b1, 8'(i) ^ 8'hA5}) begin
                errors++; $display("FAIL sweep[%0d] got %b %h exp 1 %h", i, r, v, 8'(i) ^ 8'hA5);
            end
        end
        sel(8'hC0); rd(v, r);
        checks++;
        if ({r, v} !== {1'b1, 8'hFF}) begin
            errors++; $display("FAIL unused_grp got %b %h exp 1 ff", r, v);
        end
    endtask

    task automatic test_same_cycle();
        logic [7:0] v; logic r;
        sel(8'h10);
        sel_wr = 1; data_wr = 1; din = 8'h20;
        tick();
        sel_wr = 0; data_wr = 0;
        checks++;
        if ({up_palwr, up_paladdr, up_paldata} !== {1'b1, 6'h10, 8'h20}) begin
            errors++; $display("FAIL same_req got %b %h %h exp 1 10 20", up_palwr, up_paladdr, up_paldata);
        end
        rd(v, r);
        checks++;
        if ({r, v} !== {1'b1, 8'h85}) begin
            errors++; $display("FAIL same_newsel got %b %h exp 1 85", r, v);
        end
        sel(8'h10); rd(v, r);
        checks++;
        if ({r, v} !== {1'b1, 8'h20}) begin
            errors++; $display("FAIL same_oldsel got %b %h exp 1 20", r, v);
        end
    endtask

    task automatic test_read_during_write();
        logic [7:0] v; logic r;
        sel(8'h07);
        data_wr = 1; rd_stb = 1; din = 8'h3C;
        tick();
        data_wr = 0; rd_stb = 0;
        tick();
        checks++;
        if ({dout_rdy, dout} !== {1'b1, 8'hA2}) begin
            errors++; $display("FAIL rdw_old got %b %h exp 1 a2", dout_rdy, dout);
        end
        rd(v, r);
        checks++;
        if ({r, v} !== {1'b1, 8'h3C}) begin
            errors++; $display("FAIL rdw_new got %b %h exp 1 3c", r, v);
        end
    endtask

    task automatic test_back_to_back();
        sel(8'h08);
        rd_stb = 1; tick(); tick();
        rd_stb = 0;
        checks++;
        if (dout_rdy !== 1'b0) begin
            errors++; $display("FAIL b2b_cancel got %b exp 0", dout_rdy);
        end
        tick();
        checks++;
        if ({dout_rdy, dout} !== {1'b1, 8'hAD}) begin
            errors++; $display("FAIL b2b_last got %b %h exp 1 ad", dout_rdy, dout);
        end
        tick();
        checks++;
        if ({dout_rdy, dout} !== {1'b0, 8'hAD}) begin
            errors++; $display("FAIL b2b_hold got %b %h exp 0 ad", dout_rdy, dout);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v; logic r;
        sel(8'h40); wr(8'h01);
        sel(8'h00);
        atm_palwr = 1;
        wr(8'h77);
        checks++;
        if ({up_palwr, busy, up_ena} !== 3'b111) begin
            errors++; $display("FAIL rstmid_pre got %b exp 111", {up_palwr, busy, up_ena});
        end
        rst = 1; tick(); rst = 0;
        atm_palwr = 0;
        checks++;
        if ({up_palwr, busy, up_ena} !== 3'b000) begin
            errors++; $display("FAIL rstmid_post got %b exp 000", {up_palwr, busy, up_ena});
        end
        rd(v, r);
        checks++;
        if ({r, v} !== {1'b1, 8'h77}) begin
            errors++; $display("FAIL rstmid_rd got %b %h exp 1 77", r, v);
        end
    endtask

    initial begin
        test_reset();
        test_palette_write();
        test_mode();
        test_atm();
        test_overwrite();
        test_sweep();
        test_same_cycle();
        test_read_during_write();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
